// File: rtl/mul_pkg.sv
// Shared constants and elaboration helpers for the Booth/Wallace multiplier.
// MUL_TREE_SPLIT_EN adds a register midway through the Wallace tree.
package mul_pkg;

  // Booth select code: bit2 = negate, bit1 = 2A, bit0 = 1A
  typedef enum logic [2:0] {
    ZERO = 3'b000,
    POS1 = 3'b001,
    POS2 = 3'b010,
    NEG1 = 3'b101,
    NEG2 = 3'b110
  } booth_sel_e;

`ifdef MUL_TREE_SPLIT_EN
  localparam int NUM_STAGES = 4;
`else
  localparam int NUM_STAGES = 3;
`endif

  function automatic int npp_of(input int width);
    return (width + 2) / 2;
  endfunction

  function automatic int csa_next(input int rows);
    return 2 * (rows / 3) + rows % 3;
  endfunction

  function automatic int tree_rows(input int rows0, input int lvl);
    int r = rows0;
    for (int i = 0; i < lvl; i++) r = csa_next(r);
    return r;
  endfunction

  function automatic int tree_levels(input int rows0);
    int r = rows0;
    int n = 0;
    while (r > 2) begin
      r = csa_next(r);
      n++;
    end
    return n;
  endfunction

  // First tree level whose row count has dropped to six or fewer
  function automatic int split_level(input int rows0);
    int r = rows0;
    int n = 0;
    while (r > 6) begin
      r = csa_next(r);
      n++;
    end
    return n;
  endfunction

  function automatic booth_sel_e booth_sel(input logic [2:0] trip);
    booth_sel_e s;
    case (trip)
      3'b001, 3'b010: s = POS1;
      3'b011:         s = POS2;
      3'b100:         s = NEG2;
      3'b101, 3'b110: s = NEG1;
      default:        s = ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 carry-save compressors; carry is pre-shifted into its weight.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Pipelined radix-4 Booth / Wallace multiplier: S1 recode, S2 tree, S3 final add.
// Define MUL_TREE_SPLIT_EN to register midway through the tree (latency 4).
module booth_wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW     = 2 * WIDTH;
  localparam int NPP    = npp_of(WIDTH);
  localparam int ROWS0  = NPP + 1;
  localparam int LEVELS = tree_levels(ROWS0);
  localparam int SPLIT  = split_level(ROWS0);

  logic stall, adv, accept;
  logic valid1_reg, valid2_reg, out_valid_reg;
  logic [TAG_W-1:0] tag1_reg, tag2_reg, out_tag_reg;
  logic [PW-1:0] out_prod_reg;

  assign stall     = out_valid_reg & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_reg;
  assign out_prod  = out_prod_reg;
  assign out_tag   = out_tag_reg;

  // Operand extension; b gets a zero below bit 0 for the first Booth triplet
  logic [PW-1:0]    a_ext;
  logic [WIDTH+2:0] b_ext;
  logic [PW-1:0]    pp_next [ROWS0];
  logic [PW-1:0]    neg_row;
  logic [NPP-1:0]   neg_bits;

  assign a_ext = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
  assign b_ext = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};

  for (genvar gi = 0; gi < NPP; gi++) begin : g_booth
    logic [2:0]    sel;
    logic [PW-1:0] mag;
    assign sel          = booth_sel(b_ext[2*gi +: 3]);
    assign mag          = sel[1] ? {a_ext[PW-2:0], 1'b0} : (sel[0] ? a_ext : '0);
    assign pp_next[gi]  = (sel[2] ? ~mag : mag) << (2 * gi);
    assign neg_bits[gi] = sel[2];
  end

  // The +1 of every negated row lands at that row's weight in one extra row
  always_comb begin
    neg_row = '0;
    for (int i = 0; i < NPP; i++) neg_row[2*i] = neg_bits[i];
  end
  assign pp_next[NPP] = neg_row;

  logic [PW-1:0] pp_reg [ROWS0];

  always_ff @(posedge clk) begin
    if (adv) begin
      pp_reg   <= pp_next;
      tag1_reg <= in_tag;
    end
  end

  // tree_d holds each level's outputs, tree_q what the next level consumes
  logic [PW-1:0] tree_d [LEVELS+1][ROWS0];
  logic [PW-1:0] tree_q [LEVELS+1][ROWS0];

  for (genvar gi = 0; gi < ROWS0; gi++) begin : g_lvl0
    assign tree_d[0][gi] = pp_reg[gi];
  end

  for (genvar li = 1; li <= LEVELS; li++) begin : g_lvl
    localparam int RIN  = tree_rows(ROWS0, li - 1);
    localparam int ROUT = tree_rows(ROWS0, li);
    localparam int NGRP = RIN / 3;
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_csa
      csa_row #(.W(PW)) u_csa (
        .a     (tree_q[li-1][3*gi]),
        .b     (tree_q[li-1][3*gi+1]),
        .c     (tree_q[li-1][3*gi+2]),
        .sum   (tree_d[li][2*gi]),
        .carry (tree_d[li][2*gi+1])
      );
    end
    for (genvar gi = 0; gi < RIN % 3; gi++) begin : g_pass
      assign tree_d[li][2*NGRP+gi] = tree_q[li-1][3*NGRP+gi];
    end
    for (genvar gi = ROUT; gi < ROWS0; gi++) begin : g_zero
      assign tree_d[li][gi] = '0;
    end
  end

  logic             valid_pre2;
  logic [TAG_W-1:0] tag_pre2;

`ifdef MUL_TREE_SPLIT_EN
  logic [PW-1:0]    split_reg [ROWS0];
  logic [TAG_W-1:0] tag_mid_reg;
  logic             valid_mid_reg;

  always_ff @(posedge clk) begin
    if (adv) begin
      split_reg   <= tree_d[SPLIT];
      tag_mid_reg <= tag1_reg;
    end
  end

  assign valid_pre2 = valid_mid_reg;
  assign tag_pre2   = tag_mid_reg;
`else
  assign valid_pre2 = valid1_reg;
  assign tag_pre2   = tag1_reg;
`endif

  for (genvar li = 0; li <= LEVELS; li++) begin : g_q
    for (genvar gi = 0; gi < ROWS0; gi++) begin : g_row
`ifdef MUL_TREE_SPLIT_EN
      if (li == SPLIT) begin : g_reg
        assign tree_q[li][gi] = split_reg[gi];
      end else begin : g_wire
        assign tree_q[li][gi] = tree_d[li][gi];
      end
`else
      assign tree_q[li][gi] = tree_d[li][gi];
`endif
    end
  end

  logic [PW-1:0] c_reg, s_reg;

  always_ff @(posedge clk) begin
    if (adv) begin
      s_reg    <= tree_q[LEVELS][0];
      c_reg    <= tree_q[LEVELS][1];
      tag2_reg <= tag_pre2;
    end
  end

  // Flush clears every valid even while stalled; an accept in that cycle is lost
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid1_reg    <= 1'b0;
`ifdef MUL_TREE_SPLIT_EN
      valid_mid_reg <= 1'b0;
`endif
      valid2_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_prod_reg  <= '0;
      out_tag_reg   <= '0;
    end else begin
      if (flush) begin
        valid1_reg    <= 1'b0;
`ifdef MUL_TREE_SPLIT_EN
        valid_mid_reg <= 1'b0;
`endif
        valid2_reg    <= 1'b0;
        out_valid_reg <= 1'b0;
      end else if (adv) begin
        valid1_reg    <= accept;
`ifdef MUL_TREE_SPLIT_EN
        valid_mid_reg <= valid1_reg;
`endif
        valid2_reg    <= valid_pre2;
        out_valid_reg <= valid2_reg;
      end
      if (adv) begin
        out_prod_reg <= c_reg + s_reg;
        out_tag_reg  <= tag2_reg;
      end
    end
  end

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Scoreboard bench for booth_wallace_mul_pipe: directed vectors, decoupled monitor.
module tb_booth_wallace_mul_pipe;
  import mul_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_prod;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_pop = -10;

  typedef struct {
    logic [63:0] prod;
    logic [3:0]  tag;
    int          acc;
    int          chk;   // 0 none, 1 exact latency, 2 must follow previous pop directly
  } exp_t;

  exp_t sb[$];
  exp_t e;
  bit hold_prev = 0;
  bit saw_stall = 0;
  logic [63:0] prev_prod;
  logic [3:0]  prev_tag;

  booth_wallace_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: pops and compares on every output transfer
  always @(negedge clk) begin
    if (resetn) begin
      if (hold_prev) begin
        total++;
        if (!out_valid || out_prod !== prev_prod || out_tag !== prev_tag) begin
          bad++;
          $display("FAIL hold_stable got v=%0b prod=%h tag=%0d want prod=%h tag=%0d",
                   out_valid, out_prod, out_tag, prev_prod, prev_tag);
        end
      end
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++;
        $display("FAIL in_ready got=%0b want=%0b", in_ready, !(out_valid && !out_ready));
      end
      if (!in_ready) saw_stall = 1;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out prod=%h tag=%0d", out_prod, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_prod !== e.prod || out_tag !== e.tag) begin
            bad++;
            $display("FAIL result got prod=%h tag=%0d want prod=%h tag=%0d",
                     out_prod, out_tag, e.prod, e.tag);
          end else begin
            $display("result tag=%0d prod=%h", out_tag, out_prod);
          end
          if (e.chk == 1) begin
            total++;
            if (cyc - e.acc != NUM_STAGES) begin
              bad++;
              $display("FAIL latency got=%0d want=%0d", cyc - e.acc, NUM_STAGES);
            end
          end
          if (e.chk == 2) begin
            total++;
            if (cyc != last_pop + 1) begin
              bad++;
              $display("FAIL back_to_back gap got=%0d want=1", cyc - last_pop);
            end
          end
          last_pop = cyc;
        end
      end
      hold_prev = out_valid && !out_ready && !flush;
      prev_prod = out_prod;
      prev_tag  = out_tag;
    end else begin
      hold_prev = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [63:0] want,
                      input int chk, input bit push);
    bit ok = 0;
    in_valid = 1'b1; in_signed = sg; in_a = a; in_b = b; in_tag = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout tag=%0d in_ready=%0b want=1", tag, in_ready);
    end else if (push && !flush) begin
      sb.push_back('{prod: want, tag: tag, acc: cyc, chk: chk});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  logic        tp_sg [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] tp_a  [8] = '{32'd3, 32'hFFFFFFFD, 32'h00010000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd12345};
  logic [31:0] tp_b  [8] = '{32'd5, 32'd7, 32'h00010000, 32'hFFFFFFFF,
                             32'd2, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFE};
  logic [63:0] tp_p  [8] = '{64'd15, 64'hFFFFFFFFFFFFFFEB, 64'h0000000100000000, 64'd1,
                             64'h00000001FFFFFFFE, 64'h3FFFFFFF00000001, 64'd0,
                             64'hFFFFFFFFFFFF9F8E};
  logic [63:0] bp_p  [8] = '{64'd6, 64'd12, 64'd20, 64'd30, 64'd42, 64'd56, 64'd72, 64'd90};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_prod", out_prod, 64'd0);
    check("reset_out_tag", {60'd0, out_tag}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Unsigned all-ones squared, with exact latency
    send(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 64'hFFFFFFFE00000001, 1, 1);
    drain();

    // Signed corners and a zero operand
    send(1'b1, 32'h80000000, 32'h80000000, 4'd1, 64'h4000000000000000, 0, 1);
    send(1'b1, 32'hFFFFFFFF, 32'h00000002, 4'd2, 64'hFFFFFFFFFFFFFFFE, 0, 1);
    send(1'b1, 32'h7FFFFFFF, 32'h80000000, 4'd4, 64'hC000000080000000, 0, 1);
    send(1'b1, 32'h00000000, 32'h80000000, 4'd5, 64'd0, 0, 1);
    drain();

    // Throughput: eight back-to-back accepts
    for (int i = 0; i < 8; i++)
      send(tp_sg[i], tp_a[i], tp_b[i], 4'(i), tp_p[i], (i == 0) ? 1 : 2, 1);
    drain();

    // Backpressure while streaming
    saw_stall = 0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(1'b0, 32'(k + 2), 32'(k + 3), 4'(k + 8), bp_p[k], 0, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_seen", {63'd0, saw_stall}, 64'd1);

    // Flush with the pipe partly full and an accept in the same cycle
    for (int i = 0; i < NUM_STAGES - 1; i++)
      send(1'b0, 32'd11, 32'd13, 4'(i), 64'd0, 0, 0);
    flush = 1'b1;
    send(1'b0, 32'd17, 32'd19, 4'hA, 64'd0, 0, 0);
    flush = 1'b0;
    check("flush_next_cycle", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_quiet", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send(1'b0, 32'd100, 32'd200, 4'hB, 64'd20000, 1, 1);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(1'b0, 32'd6, 32'd7, 4'd9, 64'd0, 0, 0);
    send(1'b0, 32'd8, 32'd9, 4'd12, 64'd0, 0, 0);
    begin
      bit seen = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1;
          break;
        end
      end
      check("pre_reset_valid", {63'd0, seen}, 64'd1);
    end
    check("pre_reset_prod", out_prod, 64'd42);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_reset_valid", {63'd0, out_valid}, 64'd0);
    check("async_reset_prod", out_prod, 64'd0);
    check("async_reset_tag", {60'd0, out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    send(1'b0, 32'd5, 32'd7, 4'd5, 64'd35, 1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_wallace_mul_pipe.md
Name: booth_wallace_mul_pipe

Overview:
Parametrised, pipelined radix-4 Booth / Wallace-tree integer multiplier for the execute stage, and the successor to the fixed 32-bit, 8-input combinational compressor.
- Width is generic; signed and unsigned modes are selected per operation.
- Partial-product generation, compression and the final add are split across registered stages.
- Valid/ready handshake with backpressure and a flush input for pipeline cancellation.
- One result per cycle at full throughput.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous, active-low reset
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid and in_ready are both high
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_tag  input  TAG_W  tag returned with the result
flush  input  1  cancels every in-flight operation
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_prod  output  2*WIDTH  full product
out_tag  output  TAG_W  tag of the result

Behaviour:
- Operand extension: operands extend to WIDTH+2 bits (sign-extended if in_signed, zero-extended otherwise). This gives NPP = (WIDTH+2)/2 radix-4 Booth partial products, 17 for WIDTH=32.
- Partial products: each is 2*WIDTH bits, with the negate "+1" folded in as an extra low-order row into the tree. Arithmetic wraps modulo 2^(2*WIDTH).
- Stage S1 (register at accept): Booth recode in_b, select ±0/±A/±2A, and register all NPP rows plus the negate row. Also register the tag and a valid bit.
- Stage S2: Wallace reduction of NPP+1 rows to two rows (C, S) using 3:2 compressors, with carries shifted left by 1. C, S, tag and valid are registered.
- Stage S3: C+S summed into out_prod and registered. out_valid = S3 valid.
- Latency: 3 cycles from acceptance to out_valid when there is no stall. Back-to-back accepts give one result per cycle.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stalled, every stage holds, and in_ready = ~stall.
  - No bubble collapsing is required.
- Flush:
  - All stage valid bits clear on the next edge, and out_valid is 0 on the next cycle.
  - Flush takes priority over a simultaneous accept; the accepted-looking input is dropped.
  - in_ready is unaffected by flush.
- Reset (resetn low, asynchronous):
  - All valid bits are 0, so out_valid=0.
  - out_prod and out_tag are 0.
  - Datapath registers may be left unreset except out_prod and out_tag.
  - Reset mid-operation discards everything in flight.
  - in_ready is 1 immediately after reset.
- Handshake stability: out_prod and out_tag hold stable while out_valid & ~out_ready.
- Boundaries:
  - Signed most-negative × most-negative is exact, with no overflow in 2*WIDTH.
  - Unsigned all-ones × all-ones is exact.
  - A zero operand gives 0.

Optional Feature:
Macro MUL_TREE_SPLIT_EN.
- Defined: an extra register is inserted midway through the Wallace tree, after the level where rows ≤ 6. Latency becomes 4, throughput stays 1/cycle, and stall/flush apply identically to the extra stage.
- Undefined: latency is 3 as specified above.

Decomposition:
Package mul_pkg holds:
- the Booth select encoding constants (ZERO, POS1, POS2, NEG1, NEG2);
- the function computing NPP from WIDTH;
- the stage-count localparam, which depends on MUL_TREE_SPLIT_EN.

One sub-module is natural: csa_row, a parametrised-width 3:2 carry-save compressor row. The tree is a generate loop of csa_row instances.

Test Plan:
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF, tag 3 -> out_valid exactly 3 cycles after accept (4 with MUL_TREE_SPLIT_EN), out_prod=0xFFFFFFFE00000001, out_tag=3.
- Signed checks:
  - 0x80000000 × 0x80000000 -> 0x4000000000000000.
  - 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFFFFFFFFFE.
  - 0x7FFFFFFF × 0x80000000 -> 0xC000000080000000.
- Throughput: 8 back-to-back accepts with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order, products matching the reference model.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while streaming -> in_ready drops, out_prod/out_tag stay stable, no loss or duplication.
  - Release -> remaining results drain in order.
- Flush: assert flush with 3 operations in flight plus one accept in the same cycle -> out_valid=0 the next cycle and none of the 4 results ever appears. A later accept returns its correct result after full latency.
- Reset: deassert resetn mid-stream asynchronously (between edges) -> out_valid, out_prod and out_tag read 0 immediately. After release, in_ready=1 and a 5 × 7 unsigned operation yields 35.
